// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption core: initial AddRoundKey, then one round per clock,
// with round keys expanded on the fly alongside the datapath.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  // Entry n of the forward S-box sits at bits [2047-8n -: 8].
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s = TBL[{~a, 3'b000} +: 8];
endmodule

module aes128_enc_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);
  // Handshake: start is accepted on any rising edge where busy=0 and start=1; starts
  // seen while busy are dropped. done pulses for one cycle when ciphertext updates.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_t;

  fsm_t         fsm;
  logic [127:0] state_q;
  logic [127:0] rkey_q;
  logic [3:0]   rnd;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes
  logic [127:0] sub_out;
  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (
      .a (state_q[127-8*i -: 8]),
      .s (sub_out[127-8*i -: 8])
    );
  end

  // ShiftRows: byte (r,c) takes byte (r,(c+r) mod 4).
  logic [127:0] shr_out;
  for (genvar c = 0; c < 4; c++) begin : g_shr_c
    for (genvar r = 0; r < 4; r++) begin : g_shr_r
      assign shr_out[127-8*(4*c+r) -: 8] = sub_out[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end

  // MixColumns
  logic [127:0] mix_out;
  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = shr_out[127-32*c -: 8];
    assign a1 = shr_out[119-32*c -: 8];
    assign a2 = shr_out[111-32*c -: 8];
    assign a3 = shr_out[103-32*c -: 8];
    assign mix_out[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    assign mix_out[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    assign mix_out[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    assign mix_out[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
  end

  // Key schedule: next round key from the registered one, in the same cycle it is used.
  logic [31:0] w0, w1, w2, w3, rot, subw;
  logic [31:0] n0, n1, n2, n3;
  logic [7:0]  rcon;
  logic [127:0] nkey;

  assign w0  = rkey_q[127:96];
  assign w1  = rkey_q[95:64];
  assign w2  = rkey_q[63:32];
  assign w3  = rkey_q[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subw
    aes_sbox u_sbox (
      .a (rot[31-8*i -: 8]),
      .s (subw[31-8*i -: 8])
    );
  end

  always_comb begin
    rcon = 8'h00;
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign n0   = w0 ^ subw ^ {rcon, 24'h0};
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;
  assign nkey = {n0, n1, n2, n3};

  logic [127:0] round_out, final_out;
  assign round_out = mix_out ^ nkey;
  assign final_out = shr_out ^ nkey;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      state_q    <= 128'h0;
      rkey_q     <= 128'h0;
      rnd        <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ciphertext <= 128'h0;
    end else begin
      case (fsm)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_q <= plaintext ^ key;
            rkey_q  <= key;
            rnd     <= 4'd1;
            busy    <= 1'b1;
            fsm     <= RUN;
          end
        end
        RUN: begin
          rkey_q <= nkey;
          if (rnd == 4'd10) begin
            ciphertext <= final_out;
            done       <= 1'b1;
            busy       <= 1'b0;
            fsm        <= IDLE;
          end else begin
            state_q <= round_out;
            rnd     <= rnd + 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_enc_iter.sv
// Directed FIPS-197 vectors against aes128_enc_iter, with an expected-result queue
// drained by an independent monitor on done.

module tb_aes128_enc_iter;
  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [127:0] ciphertext;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  aes128_enc_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .plaintext  (plaintext),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [127:0] exp_q[$];
  int unsigned  exp_t_q[$];
  logic [127:0] hold_ct = 128'h0;
  int checks = 0;
  int errors = 0;

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        logic [127:0] e;
        int unsigned  t;
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        check128("ciphertext", ciphertext, e);
        check_int("done_latency", cyc, t);
        check_int("busy_in_done", busy, 0);
        hold_ct = e;
      end
    end else if (rst_n) begin
      if (ciphertext !== hold_ct) begin
        checks++;
        errors++;
        $display("FAIL ct_hold: got %h expected %h", ciphertext, hold_ct);
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [127:0] pt, input logic [127:0] k,
                       input logic [127:0] ct, input bit expect_done);
    @(negedge clk);
    start     = 1'b1;
    plaintext = pt;
    key       = k;
    @(posedge clk);
    #1;
    if (expect_done) begin
      exp_q.push_back(ct);
      exp_t_q.push_back(cyc + 10);
    end
    start = 1'b0;
    @(negedge clk);
    check_int("busy_after_accept", busy, 1);
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
      exp_t_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned a;
    rst_n     = 1'b0;
    start     = 1'b0;
    plaintext = 128'h0;
    key       = 128'h0;
    repeat (3) @(negedge clk);
    check_int("reset_busy", busy, 0);
    check_int("reset_done", done, 0);
    check128("reset_ct", ciphertext, 128'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // FIPS-197 App. C.1
    issue(C1_PT, C1_KEY, C1_CT, 1'b1);
    wait_drain(30);

    // FIPS-197 App. B, with a second start and zeroed inputs while busy
    issue(B_PT, B_KEY, B_CT, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start     = 1'b1;
    plaintext = 128'h0;
    key       = 128'h0;
    @(negedge clk);
    start = 1'b0;
    wait_drain(30);
    repeat (5) @(posedge clk);

    // Back-to-back with start held high
    @(negedge clk);
    start     = 1'b1;
    plaintext = C1_PT;
    key       = C1_KEY;
    @(posedge clk);
    #1;
    a = cyc;
    exp_q.push_back(C1_CT);
    exp_t_q.push_back(a + 10);
    exp_q.push_back(B_CT);
    exp_t_q.push_back(a + 21);
    plaintext = B_PT;
    key       = B_KEY;
    repeat (11) @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain(40);

    // Reset in the middle of App. C.1: no result must ever appear
    issue(C1_PT, C1_KEY, C1_CT, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n   = 1'b0;
    hold_ct = 128'h0;
    #1;
    check_int("midreset_busy", busy, 0);
    check_int("midreset_done", done, 0);
    check128("midreset_ct", ciphertext, 128'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);

    // Fresh App. B after reset
    issue(B_PT, B_KEY, B_CT, 1'b1);
    wait_drain(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes128_enc_iter.md
# aes128_enc_iter

Iterative AES-128 encryption core, the forward-direction counterpart of the decryption datapath. It accepts one 128-bit plaintext and 128-bit cipher key per start, then performs the initial AddRoundKey and rounds 1–10 at one round per clock. Round keys are expanded on the fly. It raises a one-cycle done with the ciphertext held stable. It sits beside the decryption block in the AES top level and shares its state byte layout.

## Interface
- No parameters. AES-128 only: Nk=4, Nr=10.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only while idle (busy=0).
- plaintext  input  128  input block; sampled on the accepting edge only.
- key  input  128  cipher key; sampled on the accepting edge only.
- busy  output  1  high while rounds are in progress.
- done  output  1  one-cycle pulse; ciphertext is valid from this cycle.
- ciphertext  output  128  result; held until the next completion.

## Operation
- **Byte layout**
  - Column-major, FIPS-197 order.
  - Bits [127:96] are column 0, with row 0 in [127:120]; then columns 1–3 follow.
  - Byte n (n=0..15) occupies [127-8n -: 8]; row = n mod 4, column = n div 4.
- **Round function**
  - Rounds 1–9: SubBytes → ShiftRows → MixColumns → AddRoundKey.
  - Round 10: same, but MixColumns is skipped.
  - ShiftRows (forward): row r rotates left by r columns. Out byte (r,c) = in byte (r,(c+r) mod 4).
  - MixColumns: the standard matrix [02 03 01 01] with rows rotated, over GF(2^8). xtime reduces with 0x1B.
- **S-boxes**
  - SubBytes uses 16 instances of the codebase forward S-box (8-bit combinational lookup).
  - Key expansion uses 4 further instances for SubWord.
- **Key schedule**
  - Registered 128-bit round key w[0..3]; the next key is computed combinationally in the same cycle as the round that uses it.
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - rcon for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36, derived from the round counter.
- **FSM**
  - Two states: IDLE, RUN. 4-bit round counter rnd.
  - IDLE & start: state ← plaintext ^ key, rkey ← key, rnd ← 1, go to RUN, busy ← 1.
  - IDLE & !start: hold all registers.
  - RUN, rnd<10: state ← round(state, nextkey), rkey ← nextkey, rnd ← rnd+1.
  - RUN, rnd==10: ciphertext ← final round(state, nextkey), done ← 1, busy ← 0, go to IDLE.
- **Ignored and mid-operation events**
  - start while busy is ignored; it is neither queued nor an error.
  - Changes on plaintext/key while busy have no effect.
- **Reset**
  - Asserting rst_n=0 at any time, including mid-encryption, forces IDLE.
  - busy=0, done=0, ciphertext=0, internal state/rkey/rnd=0.
  - The aborted operation produces no done.

## Timing
- **Reset values:** busy=0, done=0, ciphertext=128'h0.
- **Latency**
  - start is sampled high in IDLE at edge E0.
  - Rounds complete at edges E1..E10.
  - done=1 and ciphertext are valid in the cycle after E10, i.e. 10 clocks after acceptance.
- **busy:** high in the cycles between E0 and E10. It is low in the done cycle.
- **done**
  - Registered, exactly one cycle wide.
  - It pulses exactly once per accepted start.
- **ciphertext:** changes only at the completion edge, then holds through any later idle period.
- **Back-to-back**
  - The FSM is already IDLE during the done cycle, so start held high then is accepted at the next edge.
  - This gives one block every 11 cycles.
- **Continuous start:** start held high permanently yields done every 11 cycles, with no lost or duplicated blocks.

## Test plan
- **FIPS-197 App. C.1:** key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, start for 1 cycle → done exactly 10 clocks after the accepting edge, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, busy low in the done cycle.
- **FIPS-197 App. B:** key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 → ciphertext 3925841d02dc09fbdc118597196a0b32.
- **Ignored start, changing inputs:** during App. B, pulse start again at round 4 and change key/plaintext to all zeros → single done, App. B result unchanged.
- **Back-to-back:** App. C.1 then App. B with start held high → dones 11 cycles apart with correct results in order; ciphertext stable between them.
- **Reset mid-operation:** drop rst_n at round 6 of App. C.1 for 2 cycles → busy=0, done=0, ciphertext=0 immediately; no done afterwards. A fresh App. B start then yields the correct result.
- **Decryption round trip:** feed App. C.1 ciphertext and key to the decryption block → recovers 00112233445566778899aabbccddeeff.
